// File: rtl/uart_serdes.sv
// uart_serdes: single-clock 8N1 serial transmitter/receiver for the PDP-8
// console (TT) controller.
//
// Bit timing comes from tick enables generated by an external baud-rate
// generator. The enables are sampled in the clk domain, so there is no
// second clock domain in this block.
//
// Ports
//   clk, reset         system clock; synchronous active-high reset
//   tx_clk             one-clk enable, once per bit period
//   tx_req/tx_ack      level handshake from the TTO state machine
//   tx_data            character to send; valid while tx_req=1
//   tx_empty           holding register empty and shifter idle (registered)
//   tx_out             serial line out; idles high
//   rx_clk             one-clk enable, OVERSAMPLE per bit period
//   rx_in              asynchronous serial line in
//   rx_req/rx_ack      level handshake from the TTI state machine
//   rx_data            last received character
//   rx_empty           low while an unread character is held
//   rx_frame_err       one-clk pulse when a stop bit is sampled low
//   rx_overrun         one-clk pulse when an unread character is overwritten
module uart_serdes #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_clk,
  input  logic                 tx_req,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ack,
  output logic                 tx_empty,
  output logic                 tx_out,
  input  logic                 rx_clk,
  input  logic                 rx_in,
  input  logic                 rx_req,
  output logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_HALF  = CW'(OVERSAMPLE / 2 - 1);

  // ---------------------------------------------------------------- TX side
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_nx;
  logic [DATA_BITS-1:0] tx_hold;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
  logic [BW-1:0]        tx_bit, tx_bit_nx;
  logic                 tx_full;
  logic                 tx_out_nx;
  logic                 tx_take;
  logic                 tx_accept;

  assign tx_accept = tx_req && !tx_ack && !tx_full;

  // Handshake and holding register; tx_accept and tx_take are mutually
  // exclusive because one needs the holding register empty, the other full.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ack   <= 1'b0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (!tx_req)        tx_ack <= 1'b0;
      else if (tx_accept) tx_ack <= 1'b1;
      if (tx_accept)      tx_full <= 1'b1;
      else if (tx_take)   tx_full <= 1'b0;
      tx_empty <= !tx_full && (tx_state == TX_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) tx_hold <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_bit   <= '0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_bit   <= tx_bit_nx;
      tx_out   <= tx_out_nx;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_nx;
  end

  // tx_out is registered and set on the same tick as the state change, so
  // each line level lasts exactly one tx_clk period.
  always_comb begin
    tx_state_nx = tx_state;
    tx_shift_nx = tx_shift;
    tx_bit_nx   = tx_bit;
    tx_out_nx   = tx_out;
    tx_take     = 1'b0;
    if (tx_clk) begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_full) begin
            tx_take     = 1'b1;
            tx_shift_nx = tx_hold;
            tx_out_nx   = 1'b0;
            tx_state_nx = TX_START;
          end
        end
        TX_START: begin
          tx_out_nx   = tx_shift[0];
          tx_shift_nx = tx_shift >> 1;
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit == BIT_LAST) begin
            tx_out_nx   = 1'b1;
            tx_state_nx = TX_STOP;
          end else begin
            tx_out_nx   = tx_shift[0];
            tx_shift_nx = tx_shift >> 1;
            tx_bit_nx   = tx_bit + BW'(1);
          end
        end
        TX_STOP: begin
          // A waiting character starts right at the end of the stop bit so
          // back-to-back characters have no idle gap on the line.
          if (tx_full) begin
            tx_take     = 1'b1;
            tx_shift_nx = tx_hold;
            tx_out_nx   = 1'b0;
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end
        default: tx_state_nx = TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  rx_state_t            rx_state, rx_state_nx;
  logic                 sync_p0, sync_p1;
  logic                 rx_line;
  logic [CW-1:0]        rx_cnt, rx_cnt_nx;
  logic [BW-1:0]        rx_bit, rx_bit_nx;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
  logic                 rx_done;
  logic                 rx_ferr;
  logic                 rx_read;

  // Two-flop synchronizer stage boundary; loads idle-high on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx_in;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_line = sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_nx;
  end

  // The start bit is re-checked half a bit after the falling edge; from then
  // on every OVERSAMPLE ticks lands in the middle of the next bit.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    rx_ferr     = 1'b0;
    if (rx_clk) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_line) begin
            rx_cnt_nx   = '0;
            rx_state_nx = RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == OS_HALF) begin
            rx_cnt_nx = '0;
            rx_bit_nx = '0;
            rx_state_nx = rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_nx = rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == OS_LAST) begin
            rx_cnt_nx   = '0;
            rx_shift_nx = {rx_line, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) rx_state_nx = RX_STOP;
            else                    rx_bit_nx   = rx_bit + BW'(1);
          end else begin
            rx_cnt_nx = rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == OS_LAST) begin
            rx_cnt_nx = '0;
            if (rx_line) begin
              rx_done     = 1'b1;
              rx_state_nx = RX_IDLE;
            end else begin
              rx_ferr     = 1'b1;
              rx_state_nx = RX_WAITHI;
            end
          end else begin
            rx_cnt_nx = rx_cnt + CW'(1);
          end
        end
        RX_WAITHI: begin
          // Hold off until the line returns high so a break is one error,
          // not a stream of false frames.
          if (rx_line) rx_state_nx = RX_IDLE;
        end
        default: rx_state_nx = RX_IDLE;
      endcase
    end
  end

  assign rx_read = rx_req && !rx_empty && !rx_ack;

  // A completing character takes priority over a read in the same clk; the
  // read stays pending and is acked one clk later with the new character.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ack       <= 1'b0;
      rx_empty     <= 1'b1;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= rx_ferr;
      rx_overrun   <= rx_done && !rx_empty;
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_empty <= 1'b0;
      end else if (rx_read) begin
        rx_ack   <= 1'b1;
        rx_empty <= 1'b1;
      end
      if (!rx_req) rx_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_serdes.sv
// tb_uart_serdes: directed self-checking bench for uart_serdes (8N1,
// OVERSAMPLE=16). Each scenario task drives its stimulus and compares the
// outputs against hand-computed values.
module tb_uart_serdes;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_clk, tx_req, tx_ack, tx_empty, tx_out;
  logic [7:0] tx_data;
  logic       rx_clk, rx_in, rx_req, rx_ack, rx_empty, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  uart_serdes #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset),
    .tx_clk(tx_clk), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ack(tx_ack), .tx_empty(tx_empty), .tx_out(tx_out),
    .rx_clk(rx_clk), .rx_in(rx_in), .rx_req(rx_req),
    .rx_ack(rx_ack), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-clk error outputs.
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_overrun === 1'b1)   ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // One tx_clk tick; returns on the negedge after the tick has taken effect.
  task automatic tx_tick();
    @(negedge clk); tx_clk = 1'b1;
    @(negedge clk); tx_clk = 1'b0;
  endtask

  // Drive ticks first..last of a 160-tick 8N1 frame (16 ticks per bit).
  task automatic rx_send(input logic [7:0] ch, input logic stop, input int first, input int last);
    for (int t = first; t <= last; t++) begin
      int b;
      b = t / 16;
      @(negedge clk);
      if (b == 0)      rx_in = 1'b0;
      else if (b <= 8) rx_in = ch[b-1];
      else             rx_in = stop;
      rx_clk = 1'b1;
      @(negedge clk); rx_clk = 1'b0;
    end
  endtask

  task automatic rx_hold(input logic v, input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk); rx_in = v; rx_clk = 1'b1;
      @(negedge clk); rx_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rst_tx_out: got %b want 1", tx_out); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_tx_empty: got %b want 1", tx_empty); end
    n_cmp++; if (tx_ack !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ack: got %b want 0", tx_ack); end
    n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ack: got %b want 0", rx_ack); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_rx_empty: got %b want 1", rx_empty); end
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got %b%b want 00", rx_frame_err, rx_overrun); end
    // Start a TX frame of 0x00 and a partial RX start bit, then reset mid-frame.
    @(negedge clk); tx_req = 1'b1; tx_data = 8'h00;
    @(negedge clk); tx_req = 1'b0;
    @(negedge clk);
    tx_tick(); tx_tick(); tx_tick();
    rx_hold(1'b0, 5);
    n_cmp++; if (tx_out !== 1'b0) begin n_fail++; $display("FAIL midframe_tx_out: got %b want 0", tx_out); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; rx_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_out: got %b want 1", tx_out); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_empty: got %b want 1", tx_empty); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_rx_empty: got %b want 1", rx_empty); end
    n_cmp++; if (tx_ack !== 1'b0 || rx_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_acks: got %b%b want 00", tx_ack, rx_ack); end
    tx_tick(); tx_tick();
    n_cmp++; if (tx_out !== 1'b1 || tx_empty !== 1'b1) begin n_fail++; $display("FAIL postrst_dropped: got out=%b empty=%b want 1 1", tx_out, tx_empty); end
  endtask

  task automatic test_tx_55();
    logic [9:0] exp;
    exp = {1'b1, 8'h55, 1'b0};
    @(negedge clk); tx_req = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    n_cmp++; if (tx_ack !== 1'b1) begin n_fail++; $display("FAIL tx55_ack_rise: got %b want 1", tx_ack); end
    tx_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_ack !== 1'b0) begin n_fail++; $display("FAIL tx55_ack_fall: got %b want 0", tx_ack); end
    n_cmp++; if (tx_empty !== 1'b0) begin n_fail++; $display("FAIL tx55_empty_held: got %b want 0", tx_empty); end
    for (int k = 0; k < 10; k++) begin
      tx_tick();
      n_cmp++; if (tx_out !== exp[k]) begin n_fail++; $display("FAIL tx55_bit%0d: got %b want %b", k, tx_out, exp[k]); end
      n_cmp++; if (tx_empty !== 1'b0) begin n_fail++; $display("FAIL tx55_empty_bit%0d: got %b want 0", k, tx_empty); end
    end
    tx_tick();
    @(negedge clk);
    n_cmp++; if (tx_empty !== 1'b1 || tx_out !== 1'b1) begin n_fail++; $display("FAIL tx55_done: got empty=%b out=%b want 1 1", tx_empty, tx_out); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    exp = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    @(negedge clk); tx_req = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      tx_tick();
      n_cmp++; if (tx_out !== exp[k]) begin n_fail++; $display("FAIL b2b_bit%0d: got %b want %b", k, tx_out, exp[k]); end
      n_cmp++; if (tx_empty !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_bit%0d: got %b want 0", k, tx_empty); end
      if (k == 0) begin
        tx_req = 1'b1; tx_data = 8'h3C;
        @(negedge clk);
        n_cmp++; if (tx_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2: got %b want 1", tx_ack); end
        tx_req = 1'b0;
        @(negedge clk);
      end
    end
    tx_tick();
    @(negedge clk);
    n_cmp++; if (tx_empty !== 1'b1 || tx_out !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got empty=%b out=%b want 1 1", tx_empty, tx_out); end
  endtask

  task automatic test_rx_4b();
    n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rx4b_pre_empty: got %b want 1", rx_empty); end
    rx_send(8'h4B, 1'b1, 0, 159);
    n_cmp++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL rx4b_empty: got %b want 0", rx_empty); end
    n_cmp++; if (rx_data !== 8'h4B) begin n_fail++; $display("FAIL rx4b_data: got %h want 4b", rx_data); end
    rx_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_ack !== 1'b1 || rx_empty !== 1'b1) begin n_fail++; $display("FAIL rx4b_read: got ack=%b empty=%b want 1 1", rx_ack, rx_empty); end
    n_cmp++; if (rx_data !== 8'h4B) begin n_fail++; $display("FAIL rx4b_hold: got %h want 4b", rx_data); end
    rx_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL rx4b_ack_fall: got %b want 0", rx_ack); end
    n_cmp++; if (ferr_cnt !== 0 || ovr_cnt !== 0) begin n_fail++; $display("FAIL rx4b_no_err: got ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt); end
  endtask

  task automatic test_rx_glitch();
    int f0;
    f0 = ferr_cnt;
    rx_hold(1'b0, 4);
    rx_hold(1'b1, 40);
    n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b want 1", rx_empty); end
    n_cmp++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want %0d", ferr_cnt, f0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cnt;
    rx_send(8'hC3, 1'b0, 0, 159);
    rx_hold(1'b0, 200);
    n_cmp++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d want %0d", ferr_cnt, f0 + 1); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_discard: got %b want 1", rx_empty); end
    rx_hold(1'b1, 4);
    rx_send(8'h5A, 1'b1, 0, 159);
    n_cmp++; if (rx_empty !== 1'b0 || rx_data !== 8'h5A) begin n_fail++; $display("FAIL ferr_recover: got empty=%b data=%h want 0 5a", rx_empty, rx_data); end
    n_cmp++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_after: got %0d want %0d", ferr_cnt, f0 + 1); end
    rx_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL ferr_read_ack: got %b want 1", rx_ack); end
    rx_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    rx_send(8'h11, 1'b1, 0, 159);
    n_cmp++; if (rx_empty !== 1'b0 || rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_first: got empty=%b data=%h want 0 11", rx_empty, rx_data); end
    rx_send(8'h22, 1'b1, 0, 152);
    // Tick 153 is the stop-bit sample: raise rx_req on the completing clk.
    @(negedge clk); rx_in = 1'b1; rx_req = 1'b1; rx_clk = 1'b1;
    @(negedge clk); rx_clk = 1'b0;
    n_cmp++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", rx_overrun); end
    n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_delayed: got %b want 0", rx_ack); end
    n_cmp++; if (rx_data !== 8'h22 || rx_empty !== 1'b0) begin n_fail++; $display("FAIL ovr_store: got data=%h empty=%b want 22 0", rx_data, rx_empty); end
    @(negedge clk);
    n_cmp++; if (rx_ack !== 1'b1 || rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_read: got ack=%b empty=%b want 1 1", rx_ack, rx_empty); end
    n_cmp++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_read_data: got %h want 22", rx_data); end
    rx_req = 1'b0;
    rx_send(8'h22, 1'b1, 154, 159);
    n_cmp++; if (ovr_cnt !== o0 + 1) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", ovr_cnt, o0 + 1); end
    n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_fall: got %b want 0", rx_ack); end
  endtask

  initial begin
    reset = 1'b1; tx_clk = 1'b0; tx_req = 1'b0; tx_data = 8'h00;
    rx_clk = 1'b0; rx_in = 1'b1; rx_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_55();
    test_back_to_back();
    test_rx_4b();
    test_rx_glitch();
    test_frame_err();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_serdes.md
Name: uart_serdes

Overview:
- Single-clock 8N1 serial transmitter/receiver that sits directly downstream of the PDP-8 console (TT) controller.
- Its req/ack/empty ports connect to that controller's TTO and TTI state machines; its tx_out/rx_in pins go to the board pins.
- Bit timing comes from baud-rate-generator tick enables, which are sampled in the clk domain; the block has no second clock domain.

Parameters:
DATA_BITS, 8, bits per character, LSB first, no parity, one stop bit.
OVERSAMPLE, 16, rx_clk ticks per bit period; must be even and at least 4.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
tx_clk  input  1  one-clk-wide enable pulse, once per bit period.
tx_req  input  1  level; the controller holds it high until tx_ack rises.
tx_data  input  DATA_BITS  character; valid while tx_req=1.
tx_ack  output  1  level acknowledge of tx_req.
tx_empty  output  1  high when the holding register is empty and the shifter is idle.
tx_out  output  1  serial line out; idles at 1.
rx_clk  input  1  one-clk-wide enable pulse, OVERSAMPLE per bit period.
rx_in  input  1  asynchronous serial line in.
rx_req  input  1  level; the controller holds it high until rx_ack rises.
rx_ack  output  1  level acknowledge of rx_req.
rx_data  output  DATA_BITS  last received character.
rx_empty  output  1  low while an unread character is held.
rx_frame_err  output  1  one-clk pulse when a bad stop bit is sampled.
rx_overrun  output  1  one-clk pulse when an unread character is overwritten.

Behaviour:
- Reset values: tx_ack=0, tx_empty=1, tx_out=1, rx_ack=0, rx_data=0, rx_empty=1, rx_frame_err=0, rx_overrun=0. Both FSMs go to IDLE and both synchronizer flops load 1.
- Reset mid-frame aborts the frame in progress and drops any partial character. tx_out returns to 1 on the next clk.
- TX accept: when tx_req=1, tx_ack=0 and the holding register is empty, latch tx_data, mark the holding register full, and set tx_ack=1 on the next clk.
- tx_ack stays 1 while tx_req=1 and clears on the first clk where tx_req=0. A new accept needs tx_ack=0 first.
- TX FSM states: IDLE, START, DATA, STOP. All advances happen only on tx_clk=1.
- IDLE: if the holding register is full, load the shifter, empty the holding register, go to START, tx_out=0.
- START: go to DATA and drive bit0.
- DATA: shift out LSB first; after DATA_BITS ticks go to STOP with tx_out=1.
- STOP: after one tick go to IDLE. If the holding register is full at that point, the next START begins on the following tick.
- A character can be accepted while the shifter is busy (double buffering).
- tx_empty = (holding register empty) AND (FSM in IDLE). Registered, so it follows that condition with one clk latency.
- RX synchronizer: rx_in passes through a 2-flop synchronizer; every RX decision below uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, WAITHI. It advances only on rx_clk=1, using a tick counter.
- IDLE: a 0 seen on a tick starts the frame: go to START, counter=0.
- START: at tick OVERSAMPLE/2-1, if the line is still 0 go to DATA with counter=0; if it is 1 it is a false start: go back to IDLE.
- DATA: sample every OVERSAMPLE ticks (mid-bit), shifting in LSB first. After DATA_BITS samples go to STOP.
- STOP: sample after OVERSAMPLE ticks.
  - Line=1: on the next clk, rx_data=character and rx_empty=0; go to IDLE.
  - Line=0: pulse rx_frame_err, discard the character, go to WAITHI.
- WAITHI: go to IDLE on the first tick that sees the line=1. This stops a break from retriggering frames.
- RX read: when rx_req=1, rx_empty=0 and rx_ack=0, on the next clk set rx_ack=1 and rx_empty=1. rx_data holds its value.
- rx_ack clears on the first clk where rx_req=0.
- Overrun: a character completing while rx_empty=0 overwrites rx_data, keeps rx_empty=0, and pulses rx_overrun.
- Completion and a read accept in the same clk: completion wins. The new character is stored, rx_overrun pulses, and rx_ack is not asserted that clk. The read is acked on the following clk and returns the new character.
- tx_clk and rx_clk are independent and may coincide on the same clk.

Test Plan:
- Reset: hold reset 3 clks while a frame is mid-transmission -> tx_out=1, tx_empty=1, rx_empty=1, all acks 0 on the clk after reset.
- TX 0x55: pulse tx_req with tx_data=8'h55 -> tx_ack rises 1 clk later and falls 1 clk after tx_req drops. tx_out over 10 tx_clk ticks is 0,1,0,1,0,1,0,1,0,1. tx_empty=0 throughout and returns to 1 after the stop tick.
- TX back-to-back: send 8'hA5 then 8'h3C, the second accepted mid-frame -> 20 contiguous bit periods with no idle gap; tx_empty stays 0 until the second stop bit ends.
- RX 0x4B at OVERSAMPLE=16 -> rx_empty falls with rx_data=8'h4B; the req/ack handshake sets rx_empty=1 and rx_ack follows rx_req.
- RX faults:
  - 4-tick low glitch -> no character and no error.
  - Frame whose stop bit is 0, followed by a held-low break -> one rx_frame_err pulse and no new frames until the line goes high.
- Overrun: receive 8'h11 and 8'h22 without reading -> rx_overrun pulses once and rx_data=8'h22. A read request landing on the clk the second character completes -> rx_ack is delayed one clk and the read returns 8'h22.
